text_cursor_writer: RTL and testbench
=====================================

Name: text_cursor_writer

Overview:
- Parametrised successor to the fixed 32x4 UART-to-text-RAM cursor logic.
- Accepts received bytes and interprets control characters (CR, LF, BS, FF).
- Produces single-cycle write commands (row, col, data) into the dual-port character RAM that the VGA text path reads.
- Optionally blanks the new line on wrap; provides cursor position for the 7-seg debug display.

Parameters:
- COLS, 32, characters per row (>=2).
- ROWS, 4, rows on screen (>=2).
- COL_W, 5, cursor column width; 2**COL_W >= COLS.
- ROW_W, 2, cursor row width; 2**ROW_W >= ROWS.
- CLEAR_ON_WRAP, 1, 1 = blank a row with spaces when the cursor enters it via wrap or LF; 0 = no blanking.
- BLANK_CHAR, 8'h20, fill byte for clears and backspace.

Ports:
- clk  in  1  system clock (100 MHz).
- reset_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte; valid while rx_valid is high.
- rx_valid  in  1  level from UART; only the rising edge is one byte.
- wr_en  out  1  one-cycle RAM write strobe.
- wr_row  out  ROW_W  write row.
- wr_col  out  COL_W  write column.
- wr_data  out  8  write byte.
- cur_row  out  ROW_W  current cursor row.
- cur_col  out  COL_W  current cursor column.
- busy  out  1  high while a row or screen clear is in progress.
- overflow  out  1  sticky; set when a byte is dropped.

Behaviour:
- Reset (async, reset_n=0): all outputs 0; state IDLE; edge register 0; holding register empty.
- Edge detect: byte is accepted at posedge N if rx_valid=1 and the registered previous rx_valid=0.
  - Level held high gives exactly one byte.
- Holding register: accepted byte goes into a 1-entry holding register.
  - If the register is already full, the byte is dropped and overflow is set (until reset).
- States:
  - IDLE: if the holding register is full, pop it and decode the byte.
  - WRITE: one cycle; wr_en=1 with the pre-advance cursor; cursor advances the same edge wr_en falls; then IDLE.
  - CLEAR_ROW: busy=1; writes BLANK_CHAR to (clr_row, 0..COLS-1), one per cycle (COLS cycles); then IDLE.
  - CLEAR_ALL: busy=1; writes BLANK_CHAR to all ROWS*COLS cells, row-major; then IDLE with cursor (0,0).
- Latency: printable byte accepted at edge N gives wr_en high during cycle N+2 when IDLE and the holding register was empty.
- Decode:
  - 0x20..0x7E: WRITE data.
    - Advance col+1.
    - At col=COLS-1: col=0, row=(row==ROWS-1)?0:row+1. If CLEAR_ON_WRAP, go to CLEAR_ROW on the new row after the WRITE.
  - 0x0D (CR): col=0, no write.
  - 0x0A (LF): row advances with the same wrap rule; col unchanged; CLEAR_ROW on the new row if CLEAR_ON_WRAP.
  - 0x08 (BS): if col>0, col=col-1 and WRITE BLANK_CHAR at the new col. If col=0, no-op (no row back-wrap).
  - 0x0C (FF): CLEAR_ALL.
  - Any other byte: discarded, no write, cursor unchanged.
- Arithmetic: cursor compares use COLS-1 and ROWS-1, not the power of two, so non-power-of-2 geometries wrap correctly.
- Bytes arriving during CLEAR are held (1 deep) and processed afterwards.
- wr_en is never high for two cells in the same cycle; wr_row/wr_col/wr_data are only meaningful while wr_en=1.
- Reset mid-CLEAR: clear is abandoned immediately; no further writes.

Optional Feature:
- Macro: TEXT_CTRL_CHARS_EN.
- Defined: control-character decode as above.
- Undefined:
  - Every accepted byte (0x00..0xFF) is written raw and advances the cursor with wrap.
  - CLEAR_ALL is unreachable.
  - CLEAR_ON_WRAP still applies.

Test Plan:
- Reset release, then rising edges with "A","B" (0x41,0x42) -> wr_en pulses at (0,0)=0x41 and (0,1)=0x42; cursor ends (0,2).
- 32 printable bytes then "Z", COLS=32 ROWS=4 CLEAR_ON_WRAP=1 -> busy high 32 cycles, blanks row 1, then 0x5A written at (1,0); cursor (1,1).
- Cursor (3,5); send 0x0D then 0x0A -> cursor (3,0) then (0,0); row 0 blanked (32 writes of 0x20).
- Cursor (2,0) BS -> no write, cursor (2,0); cursor (2,7) BS -> write 0x20 at (2,6), cursor (2,6).
- FF -> exactly 128 writes of 0x20, row-major (0,0)..(3,31); busy for 128 cycles; cursor (0,0).
- During CLEAR_ALL, send bytes 0x31, 0x32 -> 0x31 written at (0,0) after busy falls; 0x32 dropped; overflow=1 until reset_n pulse clears it.

Source files
------------

// File: rtl/text_cursor_writer.sv
// text_cursor_writer
//   Turns a stream of received bytes into single-cycle character RAM writes
//   for the VGA text path. It keeps a text cursor, wraps it at the screen edge,
//   and can blank rows. The cursor position is also exported for the 7-seg
//   debug display.
//
// Optional feature macro: TEXT_CTRL_CHARS_EN
//   Defined   : CR (0x0D), LF (0x0A), BS (0x08) and FF (0x0C) are interpreted;
//               other non-printable bytes are discarded.
//   Undefined : every accepted byte is written raw and advances the cursor.
//               CLEAR_ON_WRAP blanking still applies.
//
// Ports
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   rx_data   in   received byte, valid while rx_valid is high
//   rx_valid  in   level from the UART; only its rising edge delivers a byte
//   wr_en     out  one-cycle RAM write strobe
//   wr_row    out  write row (meaningful only while wr_en=1)
//   wr_col    out  write column (meaningful only while wr_en=1)
//   wr_data   out  write byte (meaningful only while wr_en=1)
//   cur_row   out  current cursor row
//   cur_col   out  current cursor column
//   busy      out  high while a row or screen clear is writing
//   overflow  out  sticky; set when a byte is dropped
module text_cursor_writer #(
  parameter int unsigned COLS          = 32,
  parameter int unsigned ROWS          = 4,
  parameter int unsigned COL_W         = 5,
  parameter int unsigned ROW_W         = 2,
  parameter int unsigned CLEAR_ON_WRAP = 1,
  parameter logic [7:0]  BLANK_CHAR    = 8'h20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             busy,
  output logic             overflow
);

  // Screen edges; compares use these rather than the power-of-two wrap
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITE     = 2'd1;
  localparam logic [1:0] S_CLEAR_ROW = 2'd2;
  localparam logic [1:0] S_CLEAR_ALL = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             prev_valid_q;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       hold_data_q, hold_data_d;
  logic             is_bs_q, is_bs_d;

  logic             wr_en_d;
  logic [ROW_W-1:0] wr_row_d;
  logic [COL_W-1:0] wr_col_d;
  logic [7:0]       wr_data_d;
  logic [ROW_W-1:0] cur_row_d;
  logic [COL_W-1:0] cur_col_d;
  logic             busy_d;
  logic             overflow_d;

  logic             accept;
  logic             pop;
  logic [ROW_W-1:0] row_inc;

  // Rising edge of rx_valid delivers exactly one byte
  assign accept = rx_valid & ~prev_valid_q;

  // Row below the cursor, wrapping from the last row back to row 0
  assign row_inc = (cur_row == ROW_LAST) ? '0 : ROW_W'(cur_row + 1'b1);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    is_bs_d     = is_bs_q;
    wr_en_d     = 1'b0;
    wr_row_d    = wr_row;
    wr_col_d    = wr_col;
    wr_data_d   = wr_data;
    cur_row_d   = cur_row;
    cur_col_d   = cur_col;
    busy_d      = 1'b0;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          pop = 1'b1;
`ifdef TEXT_CTRL_CHARS_EN
          if (hold_data_q >= 8'h20 && hold_data_q <= 8'h7E) begin
            state_d   = S_WRITE;
            is_bs_d   = 1'b0;
            wr_en_d   = 1'b1;
            wr_row_d  = cur_row;
            wr_col_d  = cur_col;
            wr_data_d = hold_data_q;
          end else begin
            case (hold_data_q)
              8'h0D: cur_col_d = '0;
              8'h0A: begin
                cur_row_d = row_inc;
                if (CLEAR_ON_WRAP != 0) begin
                  state_d   = S_CLEAR_ROW;
                  wr_en_d   = 1'b1;
                  busy_d    = 1'b1;
                  wr_row_d  = row_inc;
                  wr_col_d  = '0;
                  wr_data_d = BLANK_CHAR;
                end
              end
              8'h08: begin
                // No back-wrap to the previous row at column 0
                if (cur_col != '0) begin
                  state_d   = S_WRITE;
                  is_bs_d   = 1'b1;
                  wr_en_d   = 1'b1;
                  wr_row_d  = cur_row;
                  wr_col_d  = COL_W'(cur_col - 1'b1);
                  wr_data_d = BLANK_CHAR;
                end
              end
              8'h0C: begin
                state_d   = S_CLEAR_ALL;
                wr_en_d   = 1'b1;
                busy_d    = 1'b1;
                wr_row_d  = '0;
                wr_col_d  = '0;
                wr_data_d = BLANK_CHAR;
              end
              default: ;
            endcase
          end
`else
          state_d   = S_WRITE;
          is_bs_d   = 1'b0;
          wr_en_d   = 1'b1;
          wr_row_d  = cur_row;
          wr_col_d  = cur_col;
          wr_data_d = hold_data_q;
`endif
        end
      end

      // Cursor moves on the edge where the write strobe drops
      S_WRITE: begin
        state_d = S_IDLE;
        if (is_bs_q) begin
          cur_col_d = COL_W'(cur_col - 1'b1);
        end else if (cur_col == COL_LAST) begin
          cur_col_d = '0;
          cur_row_d = row_inc;
          if (CLEAR_ON_WRAP != 0) begin
            state_d   = S_CLEAR_ROW;
            wr_en_d   = 1'b1;
            busy_d    = 1'b1;
            wr_row_d  = row_inc;
            wr_col_d  = '0;
            wr_data_d = BLANK_CHAR;
          end
        end else begin
          cur_col_d = COL_W'(cur_col + 1'b1);
        end
      end

      // The write address registers double as the clear sweep counter
      S_CLEAR_ROW: begin
        if (wr_col == COL_LAST) begin
          state_d = S_IDLE;
        end else begin
          wr_en_d  = 1'b1;
          busy_d   = 1'b1;
          wr_col_d = COL_W'(wr_col + 1'b1);
        end
      end

      S_CLEAR_ALL: begin
        if (wr_col == COL_LAST && wr_row == ROW_LAST) begin
          state_d   = S_IDLE;
          cur_row_d = '0;
          cur_col_d = '0;
        end else begin
          wr_en_d = 1'b1;
          busy_d  = 1'b1;
          if (wr_col == COL_LAST) begin
            wr_col_d = '0;
            wr_row_d = ROW_W'(wr_row + 1'b1);
          end else begin
            wr_col_d = COL_W'(wr_col + 1'b1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // One-deep holding register; a pop on the same edge frees the slot
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    overflow_d  = overflow;
    if (pop) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      if (hold_full_q && !pop) begin
        overflow_d = 1'b1;
      end else begin
        hold_full_d = 1'b1;
        hold_data_d = rx_data;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      prev_valid_q <= 1'b0;
      hold_full_q  <= 1'b0;
      hold_data_q  <= '0;
      is_bs_q      <= 1'b0;
      wr_en        <= 1'b0;
      wr_row       <= '0;
      wr_col       <= '0;
      wr_data      <= '0;
      cur_row      <= '0;
      cur_col      <= '0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_valid_q <= rx_valid;
      hold_full_q  <= hold_full_d;
      hold_data_q  <= hold_data_d;
      is_bs_q      <= is_bs_d;
      wr_en        <= wr_en_d;
      wr_row       <= wr_row_d;
      wr_col       <= wr_col_d;
      wr_data      <= wr_data_d;
      cur_row      <= cur_row_d;
      cur_col      <= cur_col_d;
      busy         <= busy_d;
      overflow     <= overflow_d;
    end
  end

endmodule

// File: tb/tb_text_cursor_writer.sv
// Testbench for text_cursor_writer (default 32x4 geometry, blanking on wrap).
// A per-byte behavioural model expands every decoded byte into the list of
// cycles it must produce; one process compares the DUT to that list on every
// cycle, and directed sequences pin the model with hand-computed values.
module tb_text_cursor_writer;

  localparam int unsigned COLS  = 32;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned COL_W = 5;
  localparam int unsigned ROW_W = 2;
  localparam bit          CLR   = 1'b1;
  localparam logic [7:0]  BLANK = 8'h20;

  logic             clk;
  logic             reset_n;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic [7:0]       wr_data;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic             busy;
  logic             overflow;

  text_cursor_writer #(
    .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W),
    .CLEAR_ON_WRAP(1), .BLANK_CHAR(BLANK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected cycle of outputs
  typedef struct packed {
    logic             we;
    logic [ROW_W-1:0] r;
    logic [COL_W-1:0] c;
    logic [7:0]       d;
    logic             busy;
    logic [ROW_W-1:0] cr;
    logic [COL_W-1:0] cc;
  } exp_t;

  exp_t       script[$];
  exp_t       cur_exp;
  bit         m_prev, m_full, m_ovf;
  logic [7:0] m_hold;
  int         m_row, m_col;

  int vectors;
  int miscompares;
  int wlog[$];   // DUT writes seen, packed row*65536 + col*256 + data
  int bcount;    // DUT busy cycles seen
  bit ok;

  function automatic exp_t mk(bit we, int r, int c, int d, bit b, int cr, int cc);
    exp_t e;
    e.we = we; e.r = ROW_W'(r); e.c = COL_W'(c); e.d = 8'(d);
    e.busy = b; e.cr = ROW_W'(cr); e.cc = COL_W'(cc);
    return e;
  endfunction

  function automatic void m_reset();
    m_prev = 0; m_full = 0; m_ovf = 0; m_hold = '0;
    m_row = 0; m_col = 0;
    script.delete();
    cur_exp = '0;
  endfunction

  function automatic void add_clear_row(int row);
    for (int c = 0; c < COLS; c++) script.push_back(mk(1, row, c, BLANK, 1, m_row, m_col));
  endfunction

  // Expand one decoded byte into its cycles, ending with the idle cycle
  function automatic void plan(logic [7:0] b);
    int r0 = m_row;
    int c0 = m_col;
    bit printable;
`ifdef TEXT_CTRL_CHARS_EN
    printable = (b >= 8'h20 && b <= 8'h7E);
`else
    printable = 1'b1;
`endif
    if (printable) begin
      script.push_back(mk(1, r0, c0, b, 0, r0, c0));
      if (c0 == COLS - 1) begin
        m_col = 0;
        m_row = (r0 + 1) % ROWS;
        if (CLR) add_clear_row(m_row);
      end else begin
        m_col = c0 + 1;
      end
    end else begin
      case (b)
        8'h0D: m_col = 0;
        8'h0A: begin
          m_row = (r0 + 1) % ROWS;
          if (CLR) add_clear_row(m_row);
        end
        8'h08: if (c0 > 0) begin
          script.push_back(mk(1, r0, c0 - 1, BLANK, 0, r0, c0));
          m_col = c0 - 1;
        end
        8'h0C: begin
          for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
              script.push_back(mk(1, r, c, BLANK, 1, r0, c0));
          m_row = 0; m_col = 0;
        end
        default: ;
      endcase
    end
    script.push_back(mk(0, 0, 0, 0, 0, m_row, m_col));
  endfunction

  function automatic void m_step();
    bit acc;
    acc = rx_valid && !m_prev;
    m_prev = rx_valid;
    if (script.size() != 0) begin
      cur_exp = script.pop_front();
    end else if (m_full) begin
      m_full = 0;
      plan(m_hold);
      cur_exp = script.pop_front();
    end else begin
      cur_exp = mk(0, 0, 0, 0, 0, m_row, m_col);
    end
    if (acc) begin
      if (m_full) m_ovf = 1;
      else begin m_full = 1; m_hold = rx_data; end
    end
  endfunction

  // Model advances on the same edges as the DUT
  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else m_step();
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      vectors++;
      ok = (wr_en === cur_exp.we) && (busy === cur_exp.busy) &&
           (cur_row === cur_exp.cr) && (cur_col === cur_exp.cc) &&
           (overflow === m_ovf);
      if (cur_exp.we)
        ok = ok && (wr_row === cur_exp.r) && (wr_col === cur_exp.c) && (wr_data === cur_exp.d);
      if (!ok) begin
        miscompares++;
        $display("FAIL cycle t=%0t: got we=%0b at(%0d,%0d)=%h busy=%0b cur=(%0d,%0d) ovf=%0b; want we=%0b at(%0d,%0d)=%h busy=%0b cur=(%0d,%0d) ovf=%0b",
                 $time, wr_en, wr_row, wr_col, wr_data, busy, cur_row, cur_col, overflow,
                 cur_exp.we, cur_exp.r, cur_exp.c, cur_exp.d, cur_exp.busy, cur_exp.cr, cur_exp.cc, m_ovf);
      end
      if (wr_en === 1'b1) wlog.push_back(int'(wr_row) * 65536 + int'(wr_col) * 256 + int'(wr_data));
      if (busy === 1'b1) bcount++;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h want 'h%0h", nm, act, exp);
    end
  endtask

  function automatic int wl(int i);
    return (i < wlog.size()) ? wlog[i] : -1;
  endfunction

  task automatic clear_logs();
    wlog.delete();
    bcount = 0;
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic wait_idle(input int limit, input string nm);
    int n = 0;
    while ((script.size() != 0 || m_full) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout %s: still busy after %0d cycles, want idle", nm, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic send_w(input logic [7:0] b);
    send(b, 1);
    wait_idle(400, "send_w");
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset_n = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    logic [7:0] b;
    vectors = 0; miscompares = 0; bcount = 0;
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    check("reset wr_en", wr_en, 0);
    check("reset cur", int'(cur_row) * 256 + int'(cur_col), 0);
    check("reset overflow", overflow, 0);
    #1 reset_n = 1'b1;

    // "A","B": first write appears one edge after the accepting edge
    clear_logs();
    @(negedge clk); rx_data = 8'h41; rx_valid = 1'b1;
    @(posedge clk); #1; check("latency accept edge", wr_en, 0);
    @(posedge clk); #1; check("latency next edge we", wr_en, 1);
    check("latency next edge data", wr_data, 'h41);
    @(negedge clk); rx_valid = 1'b0;
    wait_idle(100, "A");
    send_w(8'h42);
    check("AB count", wlog.size(), 2);
    check("AB w0", wl(0), 'h00041);
    check("AB w1", wl(1), 'h00142);
    check("AB cursor", int'(cur_row) * 256 + int'(cur_col), 'h0002);

    // 32 printable then "Z": wrap blanks row 1
    do_reset(); clear_logs();
    for (int i = 0; i < 32; i++) send_w(8'h61 + 8'(i % 26));
    send_w(8'h5A);
    check("wrap count", wlog.size(), 65);
    check("wrap blank first", wl(32), 'h10020);
    check("wrap blank last", wl(63), 'h11F20);
    check("wrap Z", wl(64), 'h1005A);
    check("wrap busy cycles", bcount, 32);
    check("wrap cursor", int'(cur_row) * 256 + int'(cur_col), 'h0101);

`ifdef TEXT_CTRL_CHARS_EN
    // Cursor (3,5), then CR and LF
    do_reset();
    repeat (3) send_w(8'h0A);
    repeat (5) send_w(8'h2E);
    check("pre CR cursor", int'(cur_row) * 256 + int'(cur_col), 'h0305);
    clear_logs();
    send_w(8'h0D);
    check("CR no write", wlog.size(), 0);
    check("CR cursor", int'(cur_row) * 256 + int'(cur_col), 'h0300);
    send_w(8'h0A);
    check("LF cursor", int'(cur_row) * 256 + int'(cur_col), 'h0000);
    check("LF blanks", wlog.size(), 32);
    check("LF blank first", wl(0), 'h00020);
    check("LF blank last", wl(31), 'h01F20);

    // Backspace at column 0 and column 7
    do_reset();
    repeat (2) send_w(8'h0A);
    clear_logs();
    send_w(8'h08);
    check("BS col0 no write", wlog.size(), 0);
    check("BS col0 cursor", int'(cur_row) * 256 + int'(cur_col), 'h0200);
    repeat (7) send_w(8'h2B);
    clear_logs();
    send_w(8'h08);
    check("BS count", wlog.size(), 1);
    check("BS write", wl(0), 'h20620);
    check("BS cursor", int'(cur_row) * 256 + int'(cur_col), 'h0206);

    // Form feed clears all cells row-major
    clear_logs();
    send_w(8'h0C);
    check("FF count", wlog.size(), 128);
    check("FF first", wl(0), 'h00020);
    check("FF row1", wl(32), 'h10020);
    check("FF last", wl(127), 'h31F20);
    check("FF busy cycles", bcount, 128);
    check("FF cursor", int'(cur_row) * 256 + int'(cur_col), 0);

    // Bytes during CLEAR_ALL: one held, one dropped
    clear_logs();
    send(8'h0C, 1);
    repeat (3) @(negedge clk);
    send(8'h31, 1);
    send(8'h32, 1);
    wait_idle(400, "FF hold");
    check("hold overflow", overflow, 1);
    check("hold count", wlog.size(), 129);
    check("hold write", wl(128), 'h00031);
    check("hold cursor", int'(cur_row) * 256 + int'(cur_col), 'h0001);
    do_reset();
    check("overflow cleared", overflow, 0);

    // Reset in the middle of a clear stops all writes
    send(8'h0C, 2);
    repeat (10) @(negedge clk);
    do_reset();
    clear_logs();
    repeat (20) @(negedge clk);
    check("abandon writes", wlog.size(), 0);
    check("abandon busy", busy, 0);
`else
    // Raw mode: control bytes are plain characters
    do_reset(); clear_logs();
    send_w(8'h0C);
    send_w(8'h0A);
    check("raw count", wlog.size(), 2);
    check("raw FF", wl(0), 'h0000C);
    check("raw LF", wl(1), 'h0010A);
    check("raw cursor", int'(cur_row) * 256 + int'(cur_col), 'h0002);
`endif

    // Randomized traffic, including back-to-back bytes and mid-clear resets
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 70)      b = 8'($urandom_range(8'h20, 8'h7E));
      else if (sel < 76) b = 8'h0D;
      else if (sel < 84) b = 8'h0A;
      else if (sel < 90) b = 8'h08;
      else if (sel < 91) b = 8'h0C;
      else               b = 8'($urandom);
      send(b, $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 40)) @(negedge clk);
      if (i % 300 == 299) do_reset();
    end
    wait_idle(5000, "random drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
